// File: rtl/esd_pkg.sv
// Shared types and constants for the ESD shutdown sequencer: state encoding,
// channel-count limit and a lowest-set-bit helper for fault reporting.
package esd_pkg;

  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = $clog2(MAX_CH);

  localparam logic [2:0] ST_SAFE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  typedef enum logic [2:0] {
    SAFE  = ST_SAFE,
    START = ST_START,
    RUN   = ST_RUN,
    STOP  = ST_STOP,
    FAULT = ST_FAULT
  } seq_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [CH_IDX_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
    lowest_set = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CH_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/esd_stage_timer.sv
// Loadable down-counter for inter-stage delays. A load strobe starts a
// DLY-cycle interval; expire is high once the interval has elapsed.
module esd_stage_timer #(
  parameter int DLY = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int W = $clog2(DLY + 1);

  logic [W-1:0] count;

  // NOTE: sequential state is always written with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(DLY - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/esd_shutdown_sequencer.sv
// Staged de-energize / re-energize sequencer for ESD output channels.
// Feedback supervision and the FAULT state exist only with ESD_SEQ_FB_CHECK_EN.
module esd_shutdown_sequencer
  import esd_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int STAGE_DLY  = 50000,
  parameter int FB_TIMEOUT = 5000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trip_req,
  input  logic                restart_req,
  input  logic [N_CH-1:0]     ch_fb,
  output logic [N_CH-1:0]     ch_en,
  output logic                busy,
  output logic                running,
  output logic                seq_done,
  output logic                fault,
  output logic [CH_IDX_W-1:0] fault_ch
);

  localparam int KW = $clog2(N_CH);

  seq_state_t          state, state_nx;
  logic [KW-1:0]       k, k_nx;
  logic [N_CH-1:0]     en_nx;
  logic [CH_IDX_W-1:0] fault_ch_nx;
  logic                done_nx;
  logic                tmr_load, tmr_exp;
  logic                fb_fault;
  logic [CH_IDX_W-1:0] fb_fault_ch;

  esd_stage_timer #(.DLY(STAGE_DLY)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .expire (tmr_exp)
  );

`ifdef ESD_SEQ_FB_CHECK_EN
  localparam int MW = $clog2(FB_TIMEOUT + 1);

  logic [MW-1:0]   mis_cnt;
  logic [N_CH-1:0] diff;
  logic            mismatch;

  assign diff     = ch_fb ^ ch_en;
  assign mismatch = |diff;

  // Counts consecutive mismatching samples in RUN, saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt <= '0;
    end else if (state == RUN && mismatch) begin
      if (mis_cnt != MW'(FB_TIMEOUT)) mis_cnt <= mis_cnt + 1'b1;
    end else begin
      mis_cnt <= '0;
    end
  end

  always_comb begin
    fb_fault    = 1'b0;
    fb_fault_ch = CH_IDX_W'(k);
    if (state == START && tmr_exp && !ch_fb[k]) begin
      fb_fault = 1'b1;
    end else if (state == RUN && mismatch && mis_cnt == MW'(FB_TIMEOUT)) begin
      fb_fault    = 1'b1;
      fb_fault_ch = lowest_set(MAX_CH'(diff));
    end
  end
`else
  logic unused_fb;

  assign unused_fb   = ^ch_fb;
  assign fb_fault    = 1'b0;
  assign fb_fault_ch = '0;
`endif

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    k_nx        = k;
    en_nx       = ch_en;
    fault_ch_nx = fault_ch;
    done_nx     = 1'b0;
    tmr_load    = 1'b0;
    if (fb_fault) begin
      state_nx    = FAULT;
      en_nx       = '0;
      fault_ch_nx = fb_fault_ch;
    end else begin
      case (state)
        SAFE: begin
          if (restart_req && !trip_req) begin
            state_nx = START;
            k_nx     = '0;
            en_nx    = N_CH'(1);
            tmr_load = 1'b1;
          end
        end
        START: begin
          if (trip_req) begin
            state_nx = STOP;
            en_nx[k] = 1'b0;
            tmr_load = 1'b1;
          end else if (tmr_exp) begin
            if (k == KW'(N_CH - 1)) begin
              state_nx = RUN;
              done_nx  = 1'b1;
            end else begin
              k_nx            = k + 1'b1;
              en_nx[k + 1'b1] = 1'b1;
              tmr_load        = 1'b1;
            end
          end
        end
        RUN: begin
          if (trip_req) begin
            state_nx        = STOP;
            k_nx            = KW'(N_CH - 1);
            en_nx[N_CH - 1] = 1'b0;
            tmr_load        = 1'b1;
          end
        end
        STOP: begin
          // k is the channel most recently released; k==0 means all are off.
          if (tmr_exp) begin
            if (k == '0) begin
              state_nx = SAFE;
              done_nx  = 1'b1;
            end else begin
              en_nx[k - 1'b1] = 1'b0;
              k_nx            = k - 1'b1;
              tmr_load        = 1'b1;
            end
          end
        end
        FAULT: begin
          if (restart_req && !trip_req) begin
            state_nx    = SAFE;
            fault_ch_nx = '0;
          end
        end
        default: state_nx = SAFE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SAFE;
      k        <= '0;
      ch_en    <= '0;
      fault_ch <= '0;
      seq_done <= 1'b0;
      busy     <= 1'b0;
      running  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      ch_en    <= en_nx;
      fault_ch <= fault_ch_nx;
      seq_done <= done_nx;
      busy     <= (state_nx == START) || (state_nx == STOP);
      running  <= (state_nx == RUN);
      fault    <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_esd_shutdown_sequencer.sv
// Self-checking bench: directed scenarios plus randomized trip/restart/feedback
// traffic, compared every cycle against a timeline-based reference model.
module tb_esd_shutdown_sequencer;

  localparam int N_CH       = 4;
  localparam int STAGE_DLY  = 8;
  localparam int FB_TIMEOUT = 5;
`ifdef ESD_SEQ_FB_CHECK_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  localparam int M_SAFE  = 0;
  localparam int M_START = 1;
  localparam int M_RUN   = 2;
  localparam int M_STOP  = 3;
  localparam int M_FAULT = 4;

  logic            clk, rst_n, trip_req, restart_req;
  logic [N_CH-1:0] ch_fb, ch_en, fb_kill, en_d1, en_d2;
  logic            busy, running, seq_done, fault;
  logic [2:0]      fault_ch;

  int         mode, t, top_k, mis;
  logic       exp_done;
  logic [2:0] exp_fch;
  int         errors, checks;

  esd_shutdown_sequencer #(
    .N_CH(N_CH), .STAGE_DLY(STAGE_DLY), .FB_TIMEOUT(FB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trip_req(trip_req), .restart_req(restart_req),
    .ch_fb(ch_fb), .ch_en(ch_en), .busy(busy), .running(running),
    .seq_done(seq_done), .fault(fault), .fault_ch(fault_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Plant model: each channel's feedback contact follows its enable two cycles late.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d1 <= '0;
      en_d2 <= '0;
    end else begin
      en_d1 <= ch_en;
      en_d2 <= en_d1;
    end
  end
  assign ch_fb = en_d2 & ~fb_kill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Enables on: START grows one channel per stage, STOP shrinks one per stage.
  function automatic logic [N_CH-1:0] exp_en();
    int on;
    case (mode)
      M_START: on = t / STAGE_DLY + 1;
      M_RUN:   on = N_CH;
      M_STOP:  on = top_k - t / STAGE_DLY;
      default: on = 0;
    endcase
    if (on < 0) on = 0;
    return N_CH'((1 << on) - 1);
  endfunction

  task automatic model_reset();
    mode = M_SAFE; t = 0; top_k = 0; mis = 0; exp_done = 1'b0; exp_fch = '0;
  endtask

  task automatic model_step(input logic [N_CH-1:0] fb);
    int k;
    bit stage_end;
    logic [N_CH-1:0] bad;
    exp_done = 1'b0;
    case (mode)
      M_SAFE: if (restart_req && !trip_req) begin mode = M_START; t = 0; end
      M_START: begin
        k = t / STAGE_DLY;
        stage_end = ((t + 1) % STAGE_DLY) == 0;
        if (FB_EN && stage_end && !fb[k]) begin
          mode = M_FAULT; exp_fch = 3'(k);
        end else if (trip_req) begin
          mode = M_STOP; top_k = k; t = 0;
        end else if (stage_end && k == N_CH - 1) begin
          mode = M_RUN; mis = 0; exp_done = 1'b1;
        end else begin
          t++;
        end
      end
      M_RUN: begin
        bad = ~fb;
        mis = (bad != '0) ? mis + 1 : 0;
        if (FB_EN && mis > FB_TIMEOUT) begin
          mode = M_FAULT;
          for (int i = N_CH - 1; i >= 0; i--) if (bad[i]) exp_fch = 3'(i);
        end else if (trip_req) begin
          mode = M_STOP; top_k = N_CH - 1; t = 0;
        end
      end
      M_STOP: begin
        if (t + 1 == (top_k + 1) * STAGE_DLY) begin
          mode = M_SAFE; exp_done = 1'b1;
        end else begin
          t++;
        end
      end
      default: if (restart_req && !trip_req) begin mode = M_SAFE; exp_fch = '0; end
    endcase
  endtask

  task automatic compare_all();
    check("ch_en", 32'(ch_en), 32'(exp_en()));
    check("busy", 32'(busy), 32'(mode == M_START || mode == M_STOP));
    check("running", 32'(running), 32'(mode == M_RUN));
    check("seq_done", 32'(seq_done), 32'(exp_done));
    check("fault", 32'(fault), 32'(mode == M_FAULT));
    check("fault_ch", 32'(fault_ch), 32'(exp_fch));
  endtask

  // One clock: check outputs, then drive the inputs seen by the next edge.
  task automatic cycle(input logic trip, input logic restart, input logic [N_CH-1:0] kill);
    @(negedge clk);
    compare_all();
    trip_req = trip; restart_req = restart; fb_kill = kill;
    model_step(en_d2 & ~kill);
  endtask

  task automatic run(input int n, input logic trip, input logic [N_CH-1:0] kill);
    for (int i = 0; i < n; i++) cycle(trip, 1'b0, kill);
  endtask

  task automatic async_reset();
    @(negedge clk);
    compare_all();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    trip_req = 1'b0; restart_req = 1'b0; fb_kill = '0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    model_step(en_d2 & ~fb_kill);
  endtask

  initial begin
    logic            tr;
    logic [N_CH-1:0] kbit, kl;
    int              drop;
    errors = 0; checks = 0;
    rst_n = 1'b0; trip_req = 1'b0; restart_req = 1'b0; fb_kill = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    model_step(en_d2 & ~fb_kill);

    // Staged start to RUN, then staged stop from RUN with a restart ignored mid-stop.
    cycle(1'b0, 1'b1, '0); run(40, 1'b0, '0);
    cycle(1'b1, 1'b0, '0); run(10, 1'b0, '0);
    cycle(1'b0, 1'b1, '0); run(30, 1'b0, '0);
    // Restart while trip is still demanded is ignored in SAFE.
    cycle(1'b1, 1'b1, '0); run(4, 1'b0, '0);
    // Trip during stage 1 of START; restart during STOP ignored.
    cycle(1'b0, 1'b1, '0); run(10, 1'b0, '0);
    run(5, 1'b1, '0); cycle(1'b1, 1'b1, '0); run(20, 1'b1, '0); run(3, 1'b0, '0);
`ifdef ESD_SEQ_FB_CHECK_EN
    // Channel 2 feedback stuck off: fault at the end of stage 2.
    cycle(1'b0, 1'b1, 4'b0100); run(30, 1'b0, 4'b0100);
    cycle(1'b0, 1'b1, '0); run(5, 1'b0, '0);
    cycle(1'b0, 1'b1, '0); run(40, 1'b0, '0);
    // RUN feedback drops of 4 and 5 cycles are tolerated; 6 faults.
    run(4, 1'b0, 4'b0010); run(10, 1'b0, '0);
    run(5, 1'b0, 4'b0010); run(10, 1'b0, '0);
    run(6, 1'b0, 4'b0010); run(10, 1'b0, '0);
    cycle(1'b0, 1'b1, '0); run(3, 1'b0, '0);
    cycle(1'b0, 1'b1, '0); run(40, 1'b0, '0);
`else
    // Feedback ignored: all contacts open still reaches RUN.
    cycle(1'b0, 1'b1, '1); run(40, 1'b0, '1);
`endif
    async_reset(); run(5, 1'b0, '0);

    tr = 1'b0; drop = 0; kbit = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0) tr = ~tr;
      if (drop > 0) begin
        drop--;
      end else if (FB_EN && $urandom_range(0, 79) == 0) begin
        drop = $urandom_range(1, 9);
        kbit = N_CH'(1) << $urandom_range(0, N_CH - 1);
      end
      kl = FB_EN ? ((drop > 0) ? kbit : '0) : N_CH'($urandom);
      cycle(tr, ($urandom_range(0, 24) == 0), kl);
    end
    run(2, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esd_shutdown_sequencer.md
# esd_shutdown_sequencer

Staged actuator sequencer sitting between the ESD trip core and the physical output channels (contactors, valves, brakes). On a trip it de-energizes channels one at a time in reverse order with a fixed inter-stage delay. On a restart request it re-energizes them in forward order, verifying each channel's feedback contact before advancing. A feedback mismatch forces all channels off immediately and latches a fault with the offending channel index.

## Interface
- N_CH, 4, number of output channels (2..8)
- STAGE_DLY, 50000, clock cycles per stage (>=1); 1 ms at 50 MHz
- FB_TIMEOUT, 5000, consecutive mismatch cycles tolerated in RUN before fault (>=1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trip_req  in  1  level; 1 = shutdown demanded (from ESD core shutdown output)
- restart_req  in  1  single-cycle pulse; request staged start / fault clear
- ch_fb  in  N_CH  channel feedback, 1 = channel confirmed energized
- ch_en  out  N_CH  registered channel enables
- busy  out  1  1 in START or STOP
- running  out  1  1 in RUN
- seq_done  out  1  one-cycle pulse on STOP->SAFE and START->RUN
- fault  out  1  1 in FAULT
- fault_ch  out  3  index of channel that caused the fault, held until cleared

## Operation
- States: SAFE, START, RUN, STOP, FAULT. Reset: SAFE, ch_en=0, busy=0, running=0, seq_done=0, fault=0, fault_ch=0, stage index k=0, timer=0.
- SAFE: restart_req & !trip_req -> START, k=0, ch_en[0]=1. restart_req with trip_req=1 ignored.
- START: timer counts STAGE_DLY cycles per stage. At stage end: ch_fb[k]=0 -> FAULT, fault_ch=k; else if k<N_CH-1 -> k+1, ch_en[k+1]=1, timer reload; else -> RUN, seq_done pulse.
- START + trip_req=1 (checked before stage-end logic) -> STOP at current k, clearing ch_en[k] on entry edge.
- RUN: ch_fb compared to ch_en every cycle; mismatch counter increments while any bit differs, clears when all match; reaching FB_TIMEOUT -> FAULT, fault_ch = lowest mismatching index. trip_req=1 -> STOP, k=N_CH-1, ch_en[N_CH-1] cleared on entry edge.
- STOP: every STAGE_DLY cycles clear ch_en[k-1] and decrement k; STAGE_DLY after ch_en[0] clears -> SAFE, seq_done pulse. Feedback not checked. trip_req deassertion and restart_req ignored.
- FAULT: ch_en=0 on the entry edge (no staging). restart_req & !trip_req -> SAFE, fault=0, fault_ch=0. A second restart_req is required to start.
- Priority each cycle: FAULT entry > trip_req > stage-end advance > restart_req.

## Timing
- All outputs registered; restart_req sampled at edge N -> ch_en[0]=1 after edge N.
- ch_en[k+1] rises exactly STAGE_DLY cycles after ch_en[k]; full start = N_CH*STAGE_DLY cycles from first enable to running=1.
- Trip in RUN: ch_en[N_CH-1] falls 1 cycle after trip_req sampled; ch_en[0] falls (N_CH-1)*STAGE_DLY later; SAFE STAGE_DLY after that.
- RUN fault: ch_en=0 exactly FB_TIMEOUT+1 cycles after first mismatching sample.
- Stage timer width $clog2(STAGE_DLY+1); mismatch counter width $clog2(FB_TIMEOUT+1); both saturate, never wrap.
- rst_n low mid-sequence: all outputs to reset values asynchronously; no staged stop.

## Configuration
- ESD_SEQ_FB_CHECK_EN defined: feedback checks in START and RUN as above.
- Undefined: ch_fb ignored, START advances on timer only, FAULT unreachable, fault=0 and fault_ch=0 constant; mismatch counter not built.

## Structure
- esd_pkg: seq_state_t enum (SAFE, START, RUN, STOP, FAULT), state encoding constants, max-channel constant 8.
- One sub-module: esd_stage_timer (loadable down-counter, load/expire strobe), instanced once for stage delays.

## Test plan
- N_CH=4, STAGE_DLY=8, fb mirrors ch_en after 2 cycles; restart_req -> ch_en 0001,0011,0111,1111 at 8-cycle spacing, running=1 and seq_done pulse at cycle 32.
- From RUN, trip_req=1 -> ch_en 0111 next cycle, then 0011, 0001, 0000 at 8-cycle spacing, SAFE + seq_done 8 cycles later.
- START with ch_fb[2] stuck 0 -> at end of stage 2 ch_en=0000, fault=1, fault_ch=2; restart_req -> fault=0; second restart_req -> START.
- RUN, FB_TIMEOUT=5, ch_fb[1] drops 4 cycles then returns -> no fault; drops 6 cycles -> fault=1, fault_ch=1, ch_en=0000.
- trip_req during stage 1 of START -> ch_en 0001 next cycle, 0000 after 8 more, SAFE after another 8; restart_req during STOP ignored.
- rst_n pulsed low in RUN -> ch_en=0000, state SAFE immediately; without ESD_SEQ_FB_CHECK_EN, ch_fb=0 throughout still reaches running=1.
